// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants for the 4-bit HD44780 output stage.
// Sequencer states, strobe phases, command bytes and the init nibble table.
package lcd_pkg;

    localparam logic [2:0] S_PWR  = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_IDLE = 3'd2;
    localparam logic [2:0] S_HI   = 3'd3;
    localparam logic [2:0] S_LO   = 3'd4;
    localparam logic [2:0] S_EXEC = 3'd5;

    localparam logic [1:0] P_IDLE = 2'd0;
    localparam logic [1:0] P_SU   = 2'd1;
    localparam logic [1:0] P_EN   = 2'd2;
    localparam logic [1:0] P_GAP  = 2'd3;

    typedef enum logic [7:0] {
        CMD_CLEAR   = 8'h01,
        CMD_HOME    = 8'h02,
        CMD_ENTRY   = 8'h06,
        CMD_DISP_ON = 8'h0C,
        CMD_FUNC4   = 8'h28,
        CMD_LINE2   = 8'hC0
    } lcd_cmd_e;

    localparam logic [3:0] INIT_NIB0 = 4'h3;
    localparam logic [3:0] INIT_NIB1 = 4'h3;
    localparam logic [3:0] INIT_NIB2 = 4'h3;
    localparam logic [3:0] INIT_NIB3 = 4'h2;

    function automatic logic [3:0] init_nib(input logic [1:0] idx);
        logic [3:0] n;
        case (idx)
            2'd0:    n = INIT_NIB0;
            2'd1:    n = INIT_NIB1;
            2'd2:    n = INIT_NIB2;
            default: n = INIT_NIB3;
        endcase
        return n;
    endfunction

    // Clear and home need the long execution wait on the controller.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
        return !rs && (d == 8'(CMD_CLEAR) || d == 8'(CMD_HOME));
    endfunction

    function automatic int unsigned max_u(input int unsigned a,
                                          input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd4_byte_writer_strobe.sv
// lcd_nibble_strobe: drives one enable-strobed nibble (SU/EN/GAP) or a plain
// wait; it owns the single down-counter used for every timed phase.
module lcd_nibble_strobe
    import lcd_pkg::*;
#(
    parameter int unsigned EN_CYCLES = 800,
    parameter int unsigned CW        = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          strobe,
    input  logic          nib_rs,
    input  logic [3:0]    nib,
    input  logic [CW-1:0] gap_len,
    output logic          busy,
    output logic          done,
    output logic          lcd_en,
    output logic          lcd_rs,
    output logic [3:0]    lcd_data
);

    localparam logic [CW-1:0] EN_LOAD = CW'(EN_CYCLES - 1);

    logic [1:0]    phase;
    logic [CW-1:0] cnt;
    logic [CW-1:0] gap_q;
    logic          cnt_zero;

    assign cnt_zero = (cnt == '0);
    assign busy     = (phase != P_IDLE);
    assign done     = (phase == P_GAP) && cnt_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= P_IDLE;
            cnt      <= '0;
            gap_q    <= '0;
            lcd_en   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 4'h0;
        end else if (start) begin
            gap_q <= gap_len;
            if (strobe) begin
                phase    <= P_SU;
                lcd_rs   <= nib_rs;
                lcd_data <= nib;
            end else begin
                // Wait-only: skip the strobe, bus keeps its last value.
                phase <= P_GAP;
                cnt   <= gap_len - 1'b1;
            end
        end else begin
            case (phase)
                P_SU: begin
                    phase  <= P_EN;
                    lcd_en <= 1'b1;
                    cnt    <= EN_LOAD;
                end
                P_EN: begin
                    if (cnt_zero) begin
                        phase  <= P_GAP;
                        lcd_en <= 1'b0;
                        cnt    <= gap_q - 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                P_GAP: begin
                    if (cnt_zero) begin
                        phase <= P_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    phase <= P_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd4_byte_writer.sv
// lcd4_byte_writer: HD44780 4-bit output stage with built-in power-up init,
// byte split into two strobed nibbles and controller execution wait.
module lcd4_byte_writer
    import lcd_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES = 180000,
    parameter int unsigned EN_CYCLES      = 800,
    parameter int unsigned GAP_CYCLES     = 800,
    parameter int unsigned INITNIB_CYCLES = 60000,
    parameter int unsigned EXEC_CYCLES    = 600,
    parameter int unsigned LONG_CYCLES    = 24000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic [3:0] lcd_data
);

    localparam int unsigned MAXC =
        max_u(max_u(max_u(POWERUP_CYCLES, EN_CYCLES),
                    max_u(GAP_CYCLES, INITNIB_CYCLES)),
              max_u(EXEC_CYCLES, LONG_CYCLES));
    localparam int unsigned CW = $clog2(MAXC + 1);

    localparam logic [CW-1:0] L_PWR  = CW'(POWERUP_CYCLES);
    localparam logic [CW-1:0] L_GAP  = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] L_INIT = CW'(INITNIB_CYCLES);
    localparam logic [CW-1:0] L_EXEC = CW'(EXEC_CYCLES);
    localparam logic [CW-1:0] L_LONG = CW'(LONG_CYCLES);

    logic [2:0]    state;
    logic [2:0]    nxt;
    logic [1:0]    idx;
    logic          rs_q;
    logic [3:0]    lo_q;
    logic          long_q;

    logic          st;
    logic          strobe;
    logic          nib_rs;
    logic [3:0]    nib;
    logic [CW-1:0] gap;
    logic          busy;
    logic          done;
    logic          accept;

    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        nxt    = state;
        st     = 1'b0;
        strobe = 1'b0;
        nib_rs = 1'b0;
        nib    = 4'h0;
        gap    = L_GAP;
        case (state)
            S_PWR: begin
                if (done) begin
                    st     = 1'b1;
                    strobe = 1'b1;
                    nib    = init_nib(2'd0);
                    gap    = L_INIT;
                    nxt    = S_INIT;
                end else if (!busy) begin
                    // First cycle out of reset arms the power-up wait.
                    st  = 1'b1;
                    gap = L_PWR;
                end
            end
            S_INIT: begin
                if (done && idx == 2'd3) begin
                    nxt = S_IDLE;
                end else if (done) begin
                    st     = 1'b1;
                    strobe = 1'b1;
                    nib    = init_nib(idx + 2'd1);
                    gap    = L_INIT;
                end
            end
            S_IDLE: begin
                if (in_valid) begin
                    st     = 1'b1;
                    strobe = 1'b1;
                    nib    = in_data[7:4];
                    nib_rs = in_rs;
                    nxt    = S_HI;
                end
            end
            S_HI: begin
                if (done) begin
                    st     = 1'b1;
                    strobe = 1'b1;
                    nib    = lo_q;
                    nib_rs = rs_q;
                    nxt    = S_LO;
                end
            end
            S_LO: begin
                if (done) begin
                    st  = 1'b1;
                    gap = long_q ? L_LONG : L_EXEC;
                    nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (done) begin
                    nxt = S_IDLE;
                end
            end
            default: begin
                nxt = S_PWR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_PWR;
            idx       <= 2'd0;
            rs_q      <= 1'b0;
            lo_q      <= 4'h0;
            long_q    <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state <= nxt;
            if (state == S_INIT && done) begin
                idx <= idx + 2'd1;
            end
            if (state == S_INIT && nxt == S_IDLE) begin
                init_done <= 1'b1;
            end
            if (accept) begin
                rs_q   <= in_rs;
                lo_q   <= in_data[3:0];
                long_q <= is_long_cmd(in_rs, in_data);
            end
        end
    end

    lcd_nibble_strobe #(
        .EN_CYCLES (EN_CYCLES),
        .CW        (CW)
    ) u_strobe (
        .clk      (clk),
        .rst      (rst),
        .start    (st),
        .strobe   (strobe),
        .nib_rs   (nib_rs),
        .nib      (nib),
        .gap_len  (gap),
        .busy     (busy),
        .done     (done),
        .lcd_en   (lcd_en),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data)
    );

endmodule

// File: tb/tb_lcd4_byte_writer.sv
// tb_lcd4_byte_writer: directed and randomized checks of the 4-bit LCD writer
// against nibble/timing expectations derived from the byte-level behaviour.
module tb_lcd4_byte_writer;

    localparam int PW = 20;
    localparam int EN = 4;
    localparam int GP = 4;
    localparam int IN = 10;
    localparam int EX = 6;
    localparam int LG = 30;
    localparam int NP = 1 + EN + IN;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_rs = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       init_done;
    logic       lcd_rs;
    logic       lcd_en;
    logic [3:0] lcd_data;

    int checks = 0;
    int errors = 0;
    int edge_n = -1;

    typedef struct packed {
        logic [3:0] nib;
        logic       rs;
        int         rise;
        int         fall;
        logic       stable;
    } pulse_t;

    pulse_t pq[$];
    pulse_t cur;
    logic   in_p = 1'b0;

    lcd4_byte_writer #(
        .POWERUP_CYCLES (PW),
        .EN_CYCLES      (EN),
        .GAP_CYCLES     (GP),
        .INITNIB_CYCLES (IN),
        .EXEC_CYCLES    (EX),
        .LONG_CYCLES    (LG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs     (in_rs),
        .in_data   (in_data),
        .init_done (init_done),
        .lcd_rs    (lcd_rs),
        .lcd_en    (lcd_en),
        .lcd_data  (lcd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= -1;
        else     edge_n <= edge_n + 1;
    end

    // Observe every enable pulse: bus value at rise, edges of rise/fall.
    always @(negedge clk) begin
        if (rst) begin
            in_p <= 1'b0;
        end else if (lcd_en && !in_p) begin
            in_p <= 1'b1;
            cur  <= '{nib: lcd_data, rs: lcd_rs, rise: edge_n,
                      fall: 0, stable: 1'b1};
        end else if (lcd_en) begin
            if (lcd_data !== cur.nib || lcd_rs !== cur.rs)
                cur.stable <= 1'b0;
        end else if (in_p) begin
            in_p <= 1'b0;
            pq.push_back('{nib: cur.nib, rs: cur.rs, rise: cur.rise,
                           fall: edge_n, stable: cur.stable});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        in_data = 8'($urandom);
        in_rs   = 1'($urandom);
    endtask

    function automatic int exp_lat(input logic rs, input logic [7:0] b);
        int w;
        w = (rs == 1'b0 && (b == 8'h01 || b == 8'h02)) ? LG : EX;
        return 2 + 2 * EN + 2 * GP + w;
    endfunction

    task automatic wait_ready(input int limit, input bit scr, output int at);
        int n;
        n = 0;
        while (!in_ready && n < limit) begin
            tick();
            if (scr) scramble();
            n++;
        end
        chk("ready_timeout", in_ready, 1);
        at = edge_n;
    endtask

    task automatic check_byte(input string tag, input int t, input logic rs,
                              input logic [7:0] b);
        pulse_t p;
        int     r;
        chk({tag, "_npulse"}, (pq.size() >= 2) ? 1 : 0, 1);
        for (int h = 0; h < 2; h++) begin
            if (pq.size() == 0) break;
            p = pq.pop_front();
            r = t + 1 + h * (1 + EN + GP);
            chk({tag, "_nib"}, p.nib, (h == 0) ? (b >> 4) : (b % 16));
            chk({tag, "_rs"}, p.rs, rs);
            chk({tag, "_rise"}, p.rise, r);
            chk({tag, "_fall"}, p.fall, r + EN);
            chk({tag, "_stable"}, p.stable, 1);
        end
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b);
        int t;
        int r;
        in_valid = 1'b1;
        in_rs    = rs;
        in_data  = b;
        tick();
        t = edge_n;
        chk("accept_drop", in_ready, 0);
        in_valid = 1'b0;
        wait_ready(200, 1, r);
        chk("byte_latency", r - t, exp_lat(rs, b));
        chk("idle_lo_nib", lcd_data, b % 16);
        check_byte("byte", t, rs, b);
    endtask

    task automatic init_seq();
        pulse_t p;
        repeat (PW + 4 * NP) begin
            tick();
            scramble();
        end
        chk("init_ready_early", in_ready, 0);
        chk("init_done_early", init_done, 0);
        tick();
        chk("init_ready", in_ready, 1);
        chk("init_done", init_done, 1);
        chk("init_npulse", pq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (pq.size() == 0) break;
            p = pq.pop_front();
            chk("init_nib", p.nib, (i == 3) ? 2 : 3);
            chk("init_rs", p.rs, 0);
            chk("init_rise", p.rise, PW + i * NP + 1);
            chk("init_fall", p.fall, PW + i * NP + 1 + EN);
            chk("init_stable", p.stable, 1);
        end
    endtask

    logic [7:0] bb [3];
    int         ts [3];
    int         r;
    int         t;

    initial begin
        bb[0] = 8'h28;
        bb[1] = 8'h0C;
        bb[2] = 8'h06;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", lcd_en, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_data", lcd_data, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_done", init_done, 0);

        // Upstream presents bytes from the start; nothing may be accepted.
        in_valid = 1'b1;
        scramble();
        rst = 1'b0;
        init_seq();

        send_byte(1'b1, 8'h41);
        send_byte(1'b0, 8'h01);
        send_byte(1'b1, 8'h01);
        send_byte(1'b0, 8'h02);

        in_valid = 1'b1;
        in_rs    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_data = bb[k];
            tick();
            ts[k] = edge_n;
            chk("b2b_accept", in_ready, 0);
            if (k > 0) chk("b2b_spacing", ts[k] - ts[k-1],
                           exp_lat(1'b0, bb[k-1]) + 1);
            if (k == 2) in_valid = 1'b0;
            wait_ready(200, 0, r);
            chk("b2b_latency", r - ts[k], exp_lat(1'b0, bb[k]));
        end
        for (int k = 0; k < 3; k++) check_byte("b2b", ts[k], 1'b0, bb[k]);

        repeat (5) begin
            repeat ($urandom_range(0, 3)) tick();
            send_byte(1'($urandom), 8'($urandom));
        end

        // Reset while the low nibble enable is high.
        in_valid = 1'b1;
        in_rs    = 1'b1;
        in_data  = 8'hA5;
        tick();
        t = edge_n;
        in_valid = 1'b0;
        repeat (3 + EN + GP) tick();
        chk("pre_rst_en", lcd_en, 1);
        chk("pre_rst_data", lcd_data, 5);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_en", lcd_en, 0);
        chk("rst_async_done", init_done, 0);
        chk("rst_async_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_partial_npulse", pq.size(), 1);
        pq.delete();
        rst = 1'b0;
        init_seq();
        send_byte(1'b1, 8'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
